// File: rtl/qisp_pkg.sv
// rtl/qisp_pkg.sv - shared widths, counts and write-back destination encodings
package qisp_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 16;
    localparam int NUM_TASKS = 2;

    typedef enum logic [1:0] {
        DST_REG  = 2'b00,
        DST_QP   = 2'b01,
        DST_PC   = 2'b10,
        DST_NONE = 2'b11
    } wb_dst_e;

    // Only one destination is written per cycle: pc beats reg beats qp.
    function automatic wb_dst_e resolve_dst(input logic reg_en, input logic qp_en,
                                            input logic pc_en);
        if (pc_en)       return DST_PC;
        else if (reg_en) return DST_REG;
        else if (qp_en)  return DST_QP;
        else             return DST_NONE;
    endfunction

    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wb_regbank.sv
// rtl/wb_regbank.sv - one task's register file, PC and QP with two async read ports
module wb_regbank
    import qisp_pkg::*;
#(
    parameter int DATA_W  = qisp_pkg::DATA_W,
    parameter int PC_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  wb_dst_e           i_wr_dst,
    input  logic [3:0]        i_wr_sel,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_step,
    input  logic [3:0]        i_rd_sel_a,
    input  logic [3:0]        i_rd_sel_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_qp
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_qp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_wr_dst == DST_REG) begin
            r_regs[i_wr_sel] <= i_wr_data;
        end
    end

    // A direct PC write overrides a step landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_qp <= '0;
        end else begin
            if (i_wr_dst == DST_PC)
                r_pc <= i_wr_data;
            else if (i_step)
                r_pc <= r_pc + DATA_W'(PC_STEP);
            if (i_wr_dst == DST_QP)
                r_qp <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_regs[i_rd_sel_a];
    assign o_rd_data_b = r_regs[i_rd_sel_b];
    assign o_pc        = r_pc;
    assign o_qp        = r_qp;

endmodule

// File: rtl/task_regfile.sv
// rtl/task_regfile.sv - two-task register file with write-back bypass and registered operands
module task_regfile
    import qisp_pkg::*;
#(
    parameter int DATA_W  = qisp_pkg::DATA_W,
    parameter int PC_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              wb_reg,
    input  logic              wb_qp,
    input  logic              wb_pc,
    input  logic              wb_ts,
    input  logic [3:0]        wb_sel_rd,
    input  logic              rd_en,
    input  logic              rd_ts,
    input  logic [3:0]        rd_sel_a,
    input  logic [3:0]        rd_sel_b,
    output logic [DATA_W-1:0] opr_a,
    output logic [DATA_W-1:0] opr_b,
    output logic              opr_valid,
    input  logic              pc_step,
    input  logic              pc_ts,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] qp_out,
    output logic              wb_err
);

    wb_dst_e           w_dst;
    logic              w_multi;
    logic [DATA_W-1:0] w_rd_a [NUM_TASKS];
    logic [DATA_W-1:0] w_rd_b [NUM_TASKS];
    logic [DATA_W-1:0] w_pc   [NUM_TASKS];
    logic [DATA_W-1:0] w_qp   [NUM_TASKS];
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_nxt_a;
    logic [DATA_W-1:0] w_nxt_b;

    logic [DATA_W-1:0] r_opr_a;
    logic [DATA_W-1:0] r_opr_b;
    logic              r_opr_valid;
    logic              r_wb_err;

    assign w_dst   = resolve_dst(wb_reg, wb_qp, wb_pc);
    assign w_multi = multi_strobe(wb_reg, wb_qp, wb_pc);

    for (genvar t = 0; t < NUM_TASKS; t++) begin : g_bank
        wb_regbank #(
            .DATA_W  (DATA_W),
            .PC_STEP (PC_STEP)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_wr_dst    ((int'(wb_ts) == t) ? w_dst : DST_NONE),
            .i_wr_sel    (wb_sel_rd),
            .i_wr_data   (wb_result),
            .i_step      (pc_step && (int'(pc_ts) == t)),
            .i_rd_sel_a  (rd_sel_a),
            .i_rd_sel_b  (rd_sel_b),
            .o_rd_data_a (w_rd_a[t]),
            .o_rd_data_b (w_rd_b[t]),
            .o_pc        (w_pc[t]),
            .o_qp        (w_qp[t])
        );
    end

    // Forward only a register write that actually wins arbitration this cycle.
    assign w_byp_a = (w_dst == DST_REG) && (wb_ts == rd_ts) && (wb_sel_rd == rd_sel_a);
    assign w_byp_b = (w_dst == DST_REG) && (wb_ts == rd_ts) && (wb_sel_rd == rd_sel_b);
    assign w_nxt_a = w_byp_a ? wb_result : w_rd_a[rd_ts];
    assign w_nxt_b = w_byp_b ? wb_result : w_rd_b[rd_ts];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opr_a     <= '0;
            r_opr_b     <= '0;
            r_opr_valid <= 1'b0;
            r_wb_err    <= 1'b0;
        end else begin
            r_opr_valid <= rd_en;
            if (rd_en) begin
                r_opr_a <= w_nxt_a;
                r_opr_b <= w_nxt_b;
            end
            if (w_multi)
                r_wb_err <= 1'b1;
        end
    end

    assign opr_a     = r_opr_a;
    assign opr_b     = r_opr_b;
    assign opr_valid = r_opr_valid;
    assign wb_err    = r_wb_err;
    assign pc_out    = w_pc[pc_ts];
    assign qp_out    = w_qp[rd_ts];

endmodule

// File: tb/tb_task_regfile.sv
// tb/tb_task_regfile.sv - directed scoreboard bench for task_regfile
module tb_task_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wb_result;
    logic        wb_reg, wb_qp, wb_pc, wb_ts;
    logic [3:0]  wb_sel_rd;
    logic        rd_en, rd_ts;
    logic [3:0]  rd_sel_a, rd_sel_b;
    logic [15:0] opr_a, opr_b;
    logic        opr_valid;
    logic        pc_step, pc_ts;
    logic [15:0] pc_out, qp_out;
    logic        wb_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    task_regfile #(.DATA_W(16), .PC_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_result (wb_result),
        .wb_reg    (wb_reg),
        .wb_qp     (wb_qp),
        .wb_pc     (wb_pc),
        .wb_ts     (wb_ts),
        .wb_sel_rd (wb_sel_rd),
        .rd_en     (rd_en),
        .rd_ts     (rd_ts),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .opr_valid (opr_valid),
        .pc_step   (pc_step),
        .pc_ts     (pc_ts),
        .pc_out    (pc_out),
        .qp_out    (qp_out),
        .wb_err    (wb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented operand pair is matched against the oldest expected read.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && opr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_opr_valid", 32'(opr_valid), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("opr_pair", {opr_a, opr_b}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg = 0; wb_qp = 0; wb_pc = 0; rd_en = 0; pc_step = 0;
    endtask

    task automatic wr_reg(input logic ts, input logic [3:0] sel, input logic [15:0] d);
        wb_reg = 1; wb_ts = ts; wb_sel_rd = sel; wb_result = d;
    endtask

    task automatic rd(input logic ts, input logic [3:0] a, input logic [3:0] b,
                      input logic [15:0] ea, input logic [15:0] eb);
        rd_en = 1; rd_ts = ts; rd_sel_a = a; rd_sel_b = b;
        exp_q.push_back({ea, eb});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; wb_result = 0; wb_ts = 0; wb_sel_rd = 0;
        rd_ts = 0; rd_sel_a = 0; rd_sel_b = 0; pc_ts = 0;
        idle();
        #12;
        check("rst_opr_a", 32'(opr_a), 0);
        check("rst_opr_valid", 32'(opr_valid), 0);
        check("rst_pc_out", 32'(pc_out), 0);
        check("rst_wb_err", 32'(wb_err), 0);
        @(negedge clk); rst_n = 1;
        step();

        rd(0, 3, 7, 16'h0000, 16'h0000); step(); idle();
        wr_reg(0, 3, 16'h1111); step(); idle();
        wr_reg(0, 7, 16'h2222); step(); idle();
        rd(0, 3, 7, 16'h1111, 16'h2222); step(); idle();
        step();
        check("hold_valid_low", 32'(opr_valid), 0);
        check("hold_opr_a", 32'(opr_a), 32'h1111);

        wr_reg(1, 5, 16'h1234); rd(1, 5, 0, 16'h1234, 16'h0000); step(); idle();
        wr_reg(1, 5, 16'h1234); rd(0, 5, 3, 16'h0000, 16'h1111); step(); idle();
        rd(1, 5, 5, 16'h1234, 16'h1234); step(); idle();

        pc_ts = 0;
        wb_pc = 1; wb_ts = 0; wb_result = 16'hFFFF; step(); idle();
        check("pc0_write", 32'(pc_out), 32'hFFFF);
        pc_step = 1; step(); idle();
        check("pc0_wrap", 32'(pc_out), 32'h0000);
        wb_pc = 1; wb_ts = 0; wb_result = 16'h0040; pc_step = 1; step(); idle();
        check("pc0_wb_wins", 32'(pc_out), 32'h0040);
        wb_pc = 1; wb_ts = 1; wb_result = 16'h0100; pc_step = 1; step(); idle();
        check("pc0_step_other", 32'(pc_out), 32'h0041);
        pc_ts = 1; #1;
        check("pc1_write_other", 32'(pc_out), 32'h0100);
        pc_ts = 0;

        wb_result = 16'hDEAD; wb_ts = 0; wb_sel_rd = 3; step();
        rd(0, 3, 7, 16'h1111, 16'h2222); step(); idle();
        check("no_strobe_err", 32'(wb_err), 0);

        wr_reg(0, 3, 16'hBEEF); wb_pc = 1;
        rd(0, 3, 7, 16'h1111, 16'h2222); step(); idle();
        check("multi_pc_wins", 32'(pc_out), 32'hBEEF);
        check("multi_err_set", 32'(wb_err), 1);
        rd(0, 3, 7, 16'h1111, 16'h2222); step(); idle();
        wr_reg(0, 4, 16'h0077); wb_qp = 1; step(); idle();
        rd_ts = 0; #1;
        check("reg_beats_qp", 32'(qp_out), 0);
        rd(0, 4, 3, 16'h0077, 16'h1111); step(); idle();
        step();
        check("err_sticky", 32'(wb_err), 1);

        wb_qp = 1; wb_ts = 1; wb_result = 16'h0010; step(); idle();
        rd_ts = 1; #1;
        check("qp1_write", 32'(qp_out), 32'h0010);
        rd(1, 5, 5, 16'h1234, 16'h1234); step();
        rd_en = 1;
        @(negedge clk); #1;
        rst_n = 0; #1;
        check("arst_opr_valid", 32'(opr_valid), 0);
        check("arst_qp_out", 32'(qp_out), 0);
        check("arst_opr_a", 32'(opr_a), 0);
        check("arst_wb_err", 32'(wb_err), 0);
        step(); idle(); rst_n = 1;
        step();
        check("post_rst_valid", 32'(opr_valid), 0);
        rd(1, 5, 3, 16'h0000, 16'h0000); step(); idle();
        step(); step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
